universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised universal shift register with per-bit next-state selection (mux-per-flop style), generalising our single-bit mux-based storage element to a WIDTH-bit edge-triggered register. It holds, loads, shifts, rotates, arithmetic-shifts or clears under a 3-bit mode select. It also counts shift operations since the last load so downstream serialisers know when the word is exhausted. It is the storage and serialisation primitive for the next datapath assignments: parallel-to-serial, serial-to-parallel and barrel-less shifting.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- CW, $clog2(WIDTH+1), shift-counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  operation enable; 0 forces hold.
- mode  input  3  operation select (see Operation).
- sin_r  input  1  serial input entering the MSB on logical shift right.
- sin_l  input  1  serial input entering the LSB on shift left.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout_r  output  1  q[0]: the bit that the next right shift discards.
- sout_l  output  1  q[WIDTH-1]: the bit that the next left shift discards.
- zero  output  1  1 when q == 0.
- shift_cnt  output  CW  number of shift/rotate operations since the last load, clear or reset; saturates at WIDTH.
- drained  output  1  1 when shift_cnt == WIDTH.

## Operation
- Priority on each edge: rst, then en==0 (hold everything), then mode.
- mode 000 HOLD: q and shift_cnt unchanged.
- mode 001 SHR: q <= {sin_r, q[WIDTH-1:1]}; shift_cnt increments.
- mode 010 SHL: q <= {q[WIDTH-2:0], sin_l}; shift_cnt increments.
- mode 011 LOAD: q <= d; shift_cnt <= 0.
- mode 100 ROR: q <= {q[0], q[WIDTH-1:1]}; shift_cnt increments.
- mode 101 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; shift_cnt increments.
- mode 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; shift_cnt increments.
- mode 111 CLEAR: q <= 0; shift_cnt <= 0.
- Increment means shift_cnt <= min(shift_cnt+1, WIDTH). At WIDTH it stays at WIDTH, and the shift/rotate itself still executes.
- sin_r is ignored in every mode except SHR. sin_l is ignored in every mode except SHL. d is ignored in every mode except LOAD.
- No illegal modes: all 8 encodings are defined.

## Timing
- Reset (rst=1 at a rising edge, regardless of en/mode): q=0, shift_cnt=0. Hence sout_r=0, sout_l=0, zero=1, drained=0.
- Reset is synchronous, so outputs keep their old values until the edge. Asserting rst mid-sequence discards the in-flight operation on that edge.
- Latency: one cycle. The result of the mode sampled at edge N is visible on q immediately after edge N.
- sout_r, sout_l, zero and drained are combinational decodes of registered state: no extra latency and no glitch-relevant input paths.
- Back-to-back operations of any mode every cycle are legal. No handshake, and no stall beyond en.
- en=0 freezes both q and shift_cnt even if mode is LOAD or CLEAR.
- Boundary cases:
  - WIDTH-th consecutive shift sets drained; further shifts keep drained=1.
  - A LOAD or CLEAR on the same edge as drained clears the counter.
  - ROR/ROL by WIDTH restores the original word.

## Test plan
- Reset and hold: drive rst=1 with en=1, mode=011, d=8'hFF for one edge -> q=8'h00, zero=1, shift_cnt=0. Then HOLD for 3 cycles -> q stays 8'h00.
- Load then serialise right: LOAD d=8'hA5, then 8 x SHR with sin_r=0 -> sout_r sequence before each edge is 1,0,1,0,0,1,0,1. After the 8th edge q=8'h00, shift_cnt=8, drained=1. A 9th SHR -> shift_cnt stays 8.
- Serial in left: CLEAR, then 8 x SHL with sin_l = 1,1,0,1,0,0,1,0 -> q=8'hD2, drained=1.
- Rotate and arithmetic shift: LOAD 8'h81 -> ROL gives 8'h03, ROR gives 8'h81, ROR gives 8'hC0. Then LOAD 8'h90 -> ASR gives 8'hC8, ASR gives 8'hE4.
- Enable gating: LOAD 8'h3C, then en=0 with mode=111 for 2 cycles -> q=8'h3C and shift_cnt unchanged. Then en=1, mode=111 -> q=8'h00, zero=1.
- Reset mid-operation: LOAD 8'hF0, 3 x SHR, then rst=1 together with mode=010 -> q=8'h00, shift_cnt=0. On the next edge, rst=0 with LOAD 8'h55 -> q=8'h55.

Source files
------------

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit hold/load/shift/rotate/clear register with saturating shift counter
module universal_shift_reg #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic             zero,
   output logic [CW-1:0]    shift_cnt,
   output logic             drained
);
   typedef enum logic [2:0] {HOLD, SHR, SHL, LOAD, ROR, ROL, ASR, CLEAR} mode_t;
   logic [WIDTH-1:0] q_nxt, shr_v, shl_v;
   logic             msb_in, lsb_in, is_shift;
   logic [CW-1:0]    cnt_inc;
   always_comb begin
      msb_in   = (mode == SHR) ? sin_r : (mode == ROR) ? q[0] : q[WIDTH-1];
      lsb_in   = (mode == SHL) ? sin_l : q[WIDTH-1];
      shr_v    = {msb_in, q[WIDTH-1:1]};
      shl_v    = {q[WIDTH-2:0], lsb_in};
      q_nxt    = (mode == LOAD) ? d :
                 (mode == CLEAR) ? '0 :
                 (mode == HOLD) ? q :
                 (mode == SHL || mode == ROL) ? shl_v : shr_v;
      is_shift = mode inside {SHR, SHL, ROR, ROL, ASR};
      cnt_inc  = drained ? shift_cnt : shift_cnt + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         q         <= '0;
         shift_cnt <= '0;
      end else if (en) begin
         q         <= q_nxt;
         shift_cnt <= (mode == LOAD || mode == CLEAR) ? '0 : is_shift ? cnt_inc : shift_cnt;
      end
   end
   assign sout_r  = q[0];
   assign sout_l  = q[WIDTH-1];
   assign zero    = (q == '0);
   assign drained = (shift_cnt == CW'(WIDTH));
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: directed test plan plus random ops checked against an arithmetic model
module tb_universal_shift_reg;
   logic       clk = 0, rst = 0, en = 0, sin_r = 0, sin_l = 0;
   logic [2:0] mode = 0;
   logic [7:0] d = 0, q;
   logic       sout_r, sout_l, zero, drained;
   logic [3:0] shift_cnt;
   logic [7:0] mq = 0, saved;
   int         mcnt = 0, compared = 0, mismatched = 0;
   universal_shift_reg #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r),
      .sin_l(sin_l), .d(d), .q(q), .sout_r(sout_r), .sout_l(sout_l), .zero(zero),
      .shift_cnt(shift_cnt), .drained(drained));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic check_all();
      chk("q", q, mq);
      chk("sout_r", sout_r, mq % 2);
      chk("sout_l", sout_l, mq / 128);
      chk("zero", zero, mq == 0);
      chk("shift_cnt", shift_cnt, mcnt);
      chk("drained", drained, mcnt == 8);
   endtask
   task automatic step(input bit r, input bit e, input int m, input bit sr, input bit sl, input logic [7:0] dd);
      rst = r; en = e; mode = 3'(m); sin_r = sr; sin_l = sl; d = dd;
      @(posedge clk);
      if (r) begin
         mq = 0; mcnt = 0;
      end else if (e) begin
         case (m)
            1: mq = (mq >> 1) | (sr ? 8'h80 : 8'h00);
            2: mq = (mq << 1) | 8'(sl);
            3: mq = dd;
            4: mq = (mq >> 1) | (mq << 7);
            5: mq = (mq << 1) | (mq >> 7);
            6: mq = 8'($signed(mq) >>> 1);
            7: mq = 0;
            default: ;
         endcase
         if (m == 3 || m == 7) mcnt = 0;
         else if (m != 0) mcnt = (mcnt + 1 > 8) ? 8 : mcnt + 1;
      end
      #1;
      check_all();
   endtask
   initial begin
      bit sl_seq[8] = '{1, 1, 0, 1, 0, 0, 1, 0};
      bit sr_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      step(1, 1, 3, 0, 0, 8'hFF);
      chk("reset_q", q, 0); chk("reset_zero", zero, 1); chk("reset_cnt", shift_cnt, 0);
      repeat (3) step(0, 1, 0, 1, 1, 8'hFF);
      chk("hold_q", q, 0);
      step(0, 1, 3, 0, 0, 8'hA5);
      for (int i = 0; i < 8; i++) begin
         chk("sout_r_seq", sout_r, sr_seq[i]);
         step(0, 1, 1, 0, 1, 8'hFF);
      end
      chk("shr_q", q, 0); chk("shr_cnt", shift_cnt, 8); chk("shr_drained", drained, 1);
      step(0, 1, 1, 0, 0, 0);
      chk("shr_sat", shift_cnt, 8);
      step(0, 1, 7, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, 2, 1, sl_seq[i], 0);
      chk("shl_q", q, 8'hD2); chk("shl_drained", drained, 1);
      step(0, 1, 3, 0, 0, 8'h81);
      step(0, 1, 5, 0, 0, 0); chk("rol", q, 8'h03);
      step(0, 1, 4, 0, 0, 0); chk("ror1", q, 8'h81);
      step(0, 1, 4, 0, 0, 0); chk("ror2", q, 8'hC0);
      step(0, 1, 3, 0, 0, 8'h90);
      step(0, 1, 6, 1, 1, 0); chk("asr1", q, 8'hC8);
      step(0, 1, 6, 1, 1, 0); chk("asr2", q, 8'hE4);
      step(0, 1, 3, 0, 0, 8'h3C);
      repeat (2) step(0, 0, 7, 0, 0, 0);
      chk("en_hold_q", q, 8'h3C); chk("en_hold_cnt", shift_cnt, 0);
      step(0, 1, 7, 0, 0, 0); chk("clear_q", q, 0); chk("clear_zero", zero, 1);
      step(0, 1, 3, 0, 0, 8'hF0);
      repeat (3) step(0, 1, 1, 0, 0, 0);
      step(1, 1, 2, 1, 1, 0); chk("rst_mid_q", q, 0); chk("rst_mid_cnt", shift_cnt, 0);
      step(0, 1, 3, 0, 0, 8'h55); chk("load55", q, 8'h55);
      for (int r = 0; r < 2; r++) begin
         saved = 8'($urandom);
         step(0, 1, 3, 0, 0, saved);
         repeat (8) step(0, 1, 4 + r, 0, 0, 0);
         chk("rot8_restore", q, saved);
      end
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
              1'($urandom), 1'($urandom), 8'($urandom));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
